// File: rtl/bus_addr_pkg.sv
// bus_addr_pkg: shared FSM state type and default address map for bus_addr_ctrl
package bus_addr_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERR} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam logic [63:0] SLV_BASE_DEF = {16'hF000, 16'h8000, 16'h7000, 16'h0000};
  localparam logic [63:0] SLV_LAST_DEF = {16'hFFFF, 16'h8FFF, 16'h71FF, 16'h07FF};
endpackage

// File: rtl/bus_addr_match.sv
// bus_addr_match: inclusive unsigned range comparator for one slave window
module bus_addr_match import bus_addr_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] last,
  output logic              hit
);
  assign hit = (addr >= base) && (addr <= last);
endmodule

// File: rtl/bus_addr_ctrl.sv
// bus_addr_ctrl: address-decoding bus controller; ACTIVE timeout enabled by BUS_ADDR_CTRL_TIMEOUT_EN
module bus_addr_ctrl import bus_addr_pkg::*; #(
  parameter int                         ADDR_W   = ADDR_W_DEF,
  parameter int                         NUM_SLV  = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = SLV_BASE_DEF,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_LAST = SLV_LAST_DEF,
  parameter int                         TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_req,
  input  logic [ADDR_W-1:0]  m_addr,
  input  logic [NUM_SLV-1:0] s_ack,
  output logic [NUM_SLV-1:0] s_sel,
  output logic               m_ack,
  output logic               m_err,
  output logic               busy
);
  state_t state;
  logic [ADDR_W-1:0] addr_q, dec_addr;
  logic [NUM_SLV-1:0] hit, sel;
  logic ack_hit, timeout;
  if (NUM_SLV < 2 || NUM_SLV > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("bus_addr_ctrl: illegal parameters");
  end
  assign dec_addr = (state == IDLE) ? m_addr : addr_q;
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_match
    bus_addr_match #(.ADDR_W(ADDR_W)) u_match (
      .addr(dec_addr),
      .base(SLV_BASE[i*ADDR_W +: ADDR_W]),
      .last(SLV_LAST[i*ADDR_W +: ADDR_W]),
      .hit (hit[i])
    );
  end
  assign sel = hit & (~hit + NUM_SLV'(1));
  assign ack_hit = |(s_ack & s_sel);
  assign busy = (state != IDLE);
`ifdef BUS_ADDR_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || state != ACTIVE) ? '0 : cnt + CW'(1);
  assign timeout = (state == ACTIVE) && (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s_sel  <= '0;
      m_ack  <= 1'b0;
      m_err  <= 1'b0;
      addr_q <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        IDLE: if (m_req) begin
          addr_q <= m_addr;
          s_sel  <= sel;
          state  <= |sel ? ACTIVE : ERR;
          m_err  <= ~|sel;
        end
        ACTIVE: if (!m_req) begin
          state <= IDLE;
          s_sel <= '0;
        end else if (ack_hit) begin
          state <= DONE;
          s_sel <= '0;
          m_ack <= 1'b1;
        end else if (timeout) begin
          state <= ERR;
          s_sel <= '0;
          m_err <= 1'b1;
        end else begin
          s_sel <= sel;
        end
        default: begin
          state <= IDLE;
          s_sel <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_addr_ctrl.sv
// tb_bus_addr_ctrl: directed and randomized checks of bus_addr_ctrl against a transaction-level model
module tb_bus_addr_ctrl;
  localparam int TO = 15;
  logic clk = 1'b0, reset = 1'b1, m_req = 1'b0;
  logic [15:0] m_addr = '0;
  logic [3:0] s_ack = '0, s_sel;
  logic m_ack, m_err, busy;
  int n_cmp = 0, n_err = 0;
  logic [15:0] base_tab [4] = '{16'h0000, 16'h7000, 16'h8000, 16'hF000};
  logic [15:0] last_tab [4] = '{16'h07FF, 16'h71FF, 16'h8FFF, 16'hFFFF};
  always #5 clk = ~clk;
  bus_addr_ctrl dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .s_ack(s_ack),
    .s_sel(s_sel), .m_ack(m_ack), .m_err(m_err), .busy(busy)
  );
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic int decode(logic [15:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= base_tab[i] && a <= last_tab[i]) return i;
    return -1;
  endfunction
  function automatic logic [3:0] onehot(int idx);
    return (idx < 0) ? 4'b0000 : 4'(1 << idx);
  endfunction
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(string tag, logic [6:0] exp);
    logic [6:0] obs;
    obs = {s_sel, m_ack, m_err, busy};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed sel/ack/err/busy=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic txn(logic [15:0] a, int dly, logic [3:0] junk, logic keep);
    int idx;
    logic [3:0] e;
    idx = decode(a);
    e = onehot(idx);
    m_req = 1'b1;
    m_addr = a;
    cyc();
    if (idx < 0) begin
      chk("miss_err", 7'b0000_011);
    end else begin
      chk("accept_sel", {e, 3'b001});
      for (int k = 0; k < dly; k++) begin
        s_ack = junk & ~e;
        m_addr = 16'($urandom);
        cyc();
        chk("wait_sel", {e, 3'b001});
      end
      s_ack = e | (junk & ~e);
      cyc();
      chk("ack_done", 7'b0000_101);
    end
    s_ack = '0;
    m_req = keep;
    if (!keep) begin
      cyc();
      chk("back_idle", 7'b0000_000);
    end
  endtask
  initial begin
    m_req = 1'b1;
    m_addr = 16'h0400;
    @(negedge clk);
    cyc();
    chk("reset_hold", 7'b0);
    reset = 1'b0;
    m_req = 1'b0;
    cyc();
    chk("post_reset_idle", 7'b0);
    txn(16'h0400, 2, 4'b0000, 1'b0);
    txn(16'h71FF, 1, 4'b0000, 1'b0);
    txn(16'h7200, 0, 4'b0000, 1'b0);
    txn(16'h07FF, 0, 4'b1110, 1'b0);
    txn(16'h0800, 0, 4'b0000, 1'b0);
    txn(16'h6FFF, 0, 4'b0000, 1'b0);
    m_req = 1'b1;
    m_addr = 16'hF010;
    cyc();
    chk("abort_sel", 7'b1000_001);
    s_ack = 4'b0010;
    cyc();
    chk("abort_ignore_other", 7'b1000_001);
    s_ack = '0;
    m_req = 1'b0;
    cyc();
    chk("abort_idle", 7'b0);
    cyc();
    chk("abort_quiet", 7'b0);
    m_req = 1'b1;
    m_addr = 16'h8000;
    cyc();
    chk("rst_active_sel", 7'b0100_001);
    reset = 1'b1;
    cyc();
    chk("rst_active_clear", 7'b0);
    reset = 1'b0;
    m_req = 1'b0;
    cyc();
    chk("rst_after_idle", 7'b0);
    txn(16'h0000, 1, 4'b0000, 1'b1);
    m_addr = 16'hFFFF;
    cyc();
    chk("b2b_idle_gap", 7'b0);
    txn(16'hFFFF, 1, 4'b0000, 1'b0);
`ifdef BUS_ADDR_CTRL_TIMEOUT_EN
    m_req = 1'b1;
    m_addr = 16'h8000;
    cyc();
    for (int k = 1; k <= TO; k++) begin
      chk("to_wait", 7'b0100_001);
      cyc();
    end
    chk("to_err", 7'b0000_011);
    m_req = 1'b0;
    cyc();
    chk("to_idle", 7'b0);
    m_req = 1'b1;
    cyc();
    for (int k = 1; k < TO; k++) begin
      chk("to_ack_wait", 7'b0100_001);
      cyc();
    end
    chk("to_ack_last", 7'b0100_001);
    s_ack = 4'b0100;
    cyc();
    chk("to_ack_wins", 7'b0000_101);
    s_ack = '0;
    m_req = 1'b0;
    cyc();
    chk("to_ack_idle", 7'b0);
`else
    txn(16'h8000, 3 * TO, 4'b1011, 1'b0);
`endif
    for (int n = 0; n < 30; n++) begin
      int s;
      logic [15:0] a;
      s = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: a = base_tab[s] - 16'd1;
        1: a = base_tab[s];
        2: a = last_tab[s];
        3: a = last_tab[s] + 16'd1;
        default: a = 16'($urandom);
      endcase
      txn(a, $urandom_range(0, 8), 4'($urandom), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_addr_ctrl.md
BUS_ADDR_CTRL -- requirements
Module: bus_addr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter NUM_SLV, default 4, slave count (2..8).
REQ-003 SHALL have parameter SLV_BASE, default {16'hF000,16'h8000,16'h7000,16'h0000}, packed per-slave first address, slave 0 in LSBs.
REQ-004 SHALL have parameter SLV_LAST, default {16'hFFFF,16'h8FFF,16'h71FF,16'h07FF}, packed per-slave last address, inclusive.
REQ-005 SHALL have parameter TIMEOUT, default 15, max cycles waiting for slave ack.
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port m_req  in  1  master request, held until m_ack or m_err.
REQ-009 SHALL have port m_addr  in  ADDR_W  master address, sampled on accept.
REQ-010 SHALL have port s_ack  in  NUM_SLV  per-slave completion strobe.
REQ-011 SHALL have port s_sel  out  NUM_SLV  registered one-hot slave select.
REQ-012 SHALL have port m_ack  out  1  one-cycle completion pulse.
REQ-013 SHALL have port m_err  out  1  one-cycle error pulse (decode miss or timeout).
REQ-014 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, DONE, ERR.
REQ-016 IDLE: on m_req=1, latch m_addr and decode; hit -> ACTIVE with s_sel set next cycle; miss -> ERR.
REQ-017 A hit SHALL be base <= addr <= last, unsigned, full ADDR_W compare.
REQ-018 Overlapping ranges SHALL resolve to the lowest slave index; s_sel SHALL never have more than one bit set.
REQ-019 ACTIVE: s_sel held constant; s_ack of the selected slave -> DONE; s_ack bits of unselected slaves SHALL be ignored.
REQ-020 DONE: m_ack=1 for exactly one cycle, s_sel=0, next state IDLE.
REQ-021 ERR: m_err=1 for exactly one cycle, s_sel=0, next state IDLE.
REQ-022 Latency SHALL be: accept-to-s_sel 1 cycle; selected s_ack-to-m_ack 1 cycle; miss-to-m_err 1 cycle.
REQ-023 m_req deasserted in ACTIVE SHALL abort: next state IDLE, s_sel=0, no m_ack and no m_err.
REQ-024 m_req still high in IDLE after DONE/ERR SHALL start a new transaction; back-to-back transactions are legal.
REQ-025 s_ack arriving in the same cycle as the timeout limit SHALL win: next state DONE, not ERR.

Reset
REQ-026 reset=1 SHALL force IDLE, s_sel=0, m_ack=0, m_err=0, busy=0, timeout counter=0, latched address=0, in any state, overriding all inputs.

Configuration
REQ-027 Macro BUS_ADDR_CTRL_TIMEOUT_EN defined: counter clears on entry to ACTIVE and increments each ACTIVE cycle; TIMEOUT cycles without selected s_ack -> ERR.
REQ-028 Macro BUS_ADDR_CTRL_TIMEOUT_EN undefined: no counter; ACTIVE waits indefinitely; m_err only on decode miss; TIMEOUT parameter ignored.

Structure
REQ-029 Package bus_addr_pkg SHALL hold the FSM state enum, default ADDR_W, and default base/last constants.
REQ-030 Sub-module bus_addr_match SHALL implement one combinational range comparator, instantiated NUM_SLV times by generate.

Verification
REQ-031 m_req=1, m_addr=16'h0400; s_ack[0] 3 cycles later -> s_sel=4'b0001 after 1 cycle; m_ack pulse 1 cycle after s_ack.
REQ-032 m_addr=16'h71FF and 16'h7200 -> first gives s_sel=4'b0010; second gives m_err pulse, s_sel stays 0.
REQ-033 TIMEOUT_EN, m_addr=16'h8000, no s_ack -> ERR after 15 ACTIVE cycles, one m_err pulse; s_ack[2] on cycle 15 -> m_ack instead.
REQ-034 m_addr=16'hF010 selects slave 3; s_ack[1] pulse ignored; m_req dropped in ACTIVE -> IDLE, no m_ack/m_err.
REQ-035 reset asserted in ACTIVE with s_sel=4'b0100 -> next cycle all outputs 0, busy=0.
REQ-036 m_req held high across two transactions to 16'h0000 then 16'hFFFF -> two m_ack pulses with one IDLE cycle between.
